// File: rtl/lmc_pkg.sv
// Shared lane-management constants and the deskew controller state encoding.
package lmc_pkg;

  localparam int LANES   = 16;
  localparam int DELAY_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_LOCKED  = 3'd4,
    ST_ERROR   = 3'd5
  } deskew_state_e;

endpackage

// File: rtl/deskew_ctrl_if.sv
// Link-side signal bundle of the deskew controller: lane markers in, per-lane delays out.
interface deskew_ctrl_if #(
    parameter int LANES = lmc_pkg::LANES
);
    logic [2:0]                         GEN;
    logic [4:0]                         LANESNUMBER;
    logic                               startDeskew;
    logic [LANES-1:0]                   laneValid;
    logic [LANES-1:0]                   laneMarker;
    logic [lmc_pkg::DELAY_W*LANES-1:0]  laneDelay;
    logic                               deskewLocked;
    logic                               deskewError;
    logic [2:0]                         deskewState;

    modport master (
        output GEN, LANESNUMBER, startDeskew, laneValid, laneMarker,
        input  laneDelay, deskewLocked, deskewError, deskewState
    );

    modport slave (
        input  GEN, LANESNUMBER, startDeskew, laneValid, laneMarker,
        output laneDelay, deskewLocked, deskewError, deskewState
    );
endinterface

// File: rtl/deskew_lane_tracker.sv
// Holds the first marker arrival time of one lane for the current measurement.
module deskew_lane_tracker
    import lmc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               capture,
    input  logic [DELAY_W-1:0] stamp,
    output logic               recorded,
    output logic [DELAY_W-1:0] arrival
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            recorded <= 1'b0;
            arrival  <= '0;
        end else if (capture && !recorded) begin
            recorded <= 1'b1;
            arrival  <= stamp;
        end
    end

endmodule

// File: rtl/deskew_ctrl.sv
// Measures inter-lane marker skew after a start request and publishes per-lane delays.
module deskew_ctrl #(
    parameter int MAX_SKEW = 15,
    parameter int LANES    = lmc_pkg::LANES
) (
    input  logic         clk,
    input  logic         reset,
    deskew_ctrl_if.slave bus
);
    import lmc_pkg::*;

    localparam logic [4:0] MAX_CNT = 5'(MAX_SKEW);

    deskew_state_e state, state_nx;

    logic [2:0]               gen_q;
    logic [4:0]               lanes_q;
    logic [4:0]               skew_cnt, cnt_value;
    logic [LANES-1:0]         active, counted, recorded, capture;
    logic [DELAY_W-1:0]       arrival [LANES];
    logic [DELAY_W-1:0]       stamp, max_arrival;
    logic [DELAY_W*LANES-1:0] delay_q, delay_nx;
    logic                     cfg_ok, cfg_changed, all_seen, overrun, capture_ok, clear_arr;

    assign cfg_ok      = (bus.LANESNUMBER != 5'd0) && (bus.LANESNUMBER <= 5'(LANES));
    assign cfg_changed = (bus.GEN != gen_q) || (bus.LANESNUMBER != lanes_q);
    assign counted     = bus.laneMarker & bus.laneValid & active;
    assign cnt_value   = skew_cnt + 5'd1;
    assign overrun     = (state == ST_MEASURE) && (cnt_value > MAX_CNT);
    assign all_seen    = ((recorded | counted) & active) == active;
    assign stamp       = (state == ST_MEASURE) ? cnt_value[DELAY_W-1:0] : '0;
    // A lane past the skew budget must not be stamped; the measurement fails instead.
    assign capture_ok  = (state == ST_SEARCH) || ((state == ST_MEASURE) && !overrun);
    assign capture     = counted & {LANES{capture_ok}};
    assign clear_arr   = (state_nx == ST_SEARCH) && (state != ST_SEARCH);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign active[g] = 5'(g) < bus.LANESNUMBER;

        deskew_lane_tracker u_tracker (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear_arr),
            .capture  (capture[g]),
            .stamp    (stamp),
            .recorded (recorded[g]),
            .arrival  (arrival[g])
        );
    end

    // NOTE: every output of this block is assigned a default first, so no latch can be inferred.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:    if (bus.startDeskew) state_nx = cfg_ok ? ST_SEARCH : ST_ERROR;
            ST_SEARCH: begin
                if (cfg_changed)   state_nx = ST_IDLE;
                else if (|counted) state_nx = all_seen ? ST_COMPUTE : ST_MEASURE;
            end
            ST_MEASURE: begin
                if (cfg_changed)   state_nx = ST_IDLE;
                else if (overrun)  state_nx = ST_ERROR;
                else if (all_seen) state_nx = ST_COMPUTE;
            end
            ST_COMPUTE: state_nx = ST_LOCKED;
            ST_LOCKED: begin
                if (bus.startDeskew) state_nx = cfg_ok ? ST_SEARCH : ST_ERROR;
                else if (cfg_changed) state_nx = ST_IDLE;
            end
            ST_ERROR:   if (bus.startDeskew) state_nx = cfg_ok ? ST_SEARCH : ST_ERROR;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // NOTE: blocking assignments here let max_arrival accumulate across loop iterations.
    always_comb begin
        max_arrival = '0;
        for (int i = 0; i < LANES; i++)
            if (active[i] && (arrival[i] > max_arrival)) max_arrival = arrival[i];

        delay_nx = delay_q;
        if (state == ST_COMPUTE) begin
            for (int i = 0; i < LANES; i++)
                delay_nx[DELAY_W*i +: DELAY_W] = active[i] ? (max_arrival - arrival[i]) : '0;
        end else if ((state == ST_LOCKED) && (state_nx == ST_IDLE)) begin
            delay_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            skew_cnt <= '0;
            delay_q  <= '0;
            gen_q    <= '0;
            lanes_q  <= '0;
        end else begin
            state    <= state_nx;
            skew_cnt <= (state == ST_MEASURE) ? cnt_value : 5'd0;
            delay_q  <= delay_nx;
            if (clear_arr) begin
                gen_q   <= bus.GEN;
                lanes_q <= bus.LANESNUMBER;
            end
        end
    end

    assign bus.laneDelay    = delay_q;
    assign bus.deskewLocked = (state == ST_LOCKED);
    assign bus.deskewError  = (state == ST_ERROR);
    assign bus.deskewState  = state;

endmodule

// File: tb/tb_deskew_ctrl.sv
// Directed bench for deskew_ctrl: marker schedules checked against an arrival-time model.
module tb_deskew_ctrl;
    import lmc_pkg::*;

    localparam int NL   = 16;
    localparam int MAXS = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    deskew_ctrl_if #(.LANES(NL)) bus ();

    deskew_ctrl #(.MAX_SKEW(MAXS), .LANES(NL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int            vectors     = 0;
    int            miscompares = 0;
    bit            chk_en      = 1'b0;
    deskew_state_e exp_state   = ST_IDLE;
    logic [4*NL-1:0] exp_delay = '0;
    logic [NL-1:0] mk [32];
    logic [NL-1:0] vd [32];
    int            dc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Every cycle, compare the outputs against the model's expected state and delays.
    always @(negedge clk) begin
        if (chk_en) begin
            check("state",  64'(bus.deskewState),  64'(exp_state));
            check("locked", 64'(bus.deskewLocked), 64'(exp_state == ST_LOCKED));
            check("error",  64'(bus.deskewError),  64'(exp_state == ST_ERROR));
            check("delay",  64'(bus.laneDelay),    64'(exp_delay));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched();
        for (int c = 0; c < 32; c++) begin
            mk[c] = '0;
            vd[c] = '1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.startDeskew = 1'b0;
        bus.laneMarker  = '0;
        bus.laneValid   = '1;
        tick();
        reset     = 1'b0;
        exp_state = ST_IDLE;
        exp_delay = '0;
        chk_en    = 1'b1;
    endtask

    task automatic start(input logic [4:0] ln, input deskew_state_e exp_next);
        bus.LANESNUMBER = ln;
        bus.startDeskew = 1'b1;
        tick();
        bus.startDeskew = 1'b0;
        exp_state = exp_next;
    endtask

    // Two SEARCH cycles of noise: an inactive-lane marker with a stray start, then an invalid marker.
    task automatic search_wait(input int ln);
        bus.laneMarker = '0;
        if (ln + 1 < NL) bus.laneMarker[ln+1] = 1'b1;
        bus.startDeskew = 1'b1;
        tick();
        exp_state = ST_SEARCH;
        bus.startDeskew = 1'b0;
        bus.laneMarker = '0;
        bus.laneMarker[0] = 1'b1;
        bus.laneValid = '1;
        bus.laneValid[0] = 1'b0;
        tick();
        exp_state = ST_SEARCH;
        bus.laneMarker = '0;
        bus.laneValid  = '1;
    endtask

    // Cycle 0 is the first counted marker; a lane's arrival is the cycle of its first counted marker.
    task automatic measure(input int ln, input int n, output int done_c);
        logic [NL-1:0] act, rec, cm;
        int arr [NL];
        int mx;
        bit done;
        act = '0;
        rec = '0;
        done = 1'b0;
        done_c = -1;
        for (int i = 0; i < NL; i++) begin
            act[i] = (i < ln);
            arr[i] = 0;
        end
        for (int c = 0; !done; c++) begin
            bus.laneMarker = (c < n) ? mk[c] : '0;
            bus.laneValid  = (c < n) ? vd[c] : '1;
            cm = bus.laneMarker & bus.laneValid & act;
            tick();
            if (c > MAXS) begin
                exp_state = ST_ERROR;
                done = 1'b1;
            end else begin
                for (int i = 0; i < NL; i++)
                    if (cm[i] && !rec[i]) begin
                        arr[i] = c;
                        rec[i] = 1'b1;
                    end
                if (rec == act) begin
                    exp_state = ST_COMPUTE;
                    done = 1'b1;
                    done_c = c;
                end else begin
                    exp_state = ST_MEASURE;
                end
            end
        end
        bus.laneMarker = '0;
        bus.laneValid  = '1;
        if (exp_state == ST_COMPUTE) begin
            mx = 0;
            for (int i = 0; i < NL; i++)
                if (act[i] && arr[i] > mx) mx = arr[i];
            tick();
            exp_state = ST_LOCKED;
            for (int i = 0; i < NL; i++)
                exp_delay[4*i +: 4] = act[i] ? 4'(mx - arr[i]) : 4'd0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bus.GEN = 3'd2;
        bus.LANESNUMBER = 5'd0;
        do_reset();
        check("reset_state",  64'(bus.deskewState),  64'(ST_IDLE));
        check("reset_delay",  64'(bus.laneDelay),    64'd0);
        check("reset_locked", 64'(bus.deskewLocked), 64'd0);

        // x4, lanes 0..3 arrive at 0,2,1,3 with a duplicate lane-0 marker
        start(5'd4, ST_SEARCH);
        search_wait(4);
        clear_sched();
        mk[0] = 16'h0001; mk[1] = 16'h0005; mk[2] = 16'h0002; mk[3] = 16'h0008;
        measure(4, 4, dc);
        check("x4_last_cycle", 64'(dc), 64'd3);
        check("x4_delays",     64'(bus.laneDelay), 64'h0213);
        check("x4_locked",     64'(bus.deskewLocked), 64'd1);

        // Restart from LOCKED; lanes 1..3 never mark, delays hold through ERROR
        start(5'd4, ST_SEARCH);
        check("restart_drop", 64'(bus.deskewLocked), 64'd0);
        search_wait(4);
        clear_sched();
        mk[0] = 16'h0001;
        measure(4, 1, dc);
        check("err_hold_delay", 64'(bus.laneDelay), 64'h0213);
        check("err_flag",       64'(bus.deskewError), 64'd1);

        // From ERROR restart, then reset mid-MEASURE
        start(5'd4, ST_SEARCH);
        bus.laneMarker = 16'h0001;
        tick();
        exp_state = ST_MEASURE;
        bus.laneMarker = '0;
        tick();
        bus.laneMarker = 16'h0002;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.laneMarker = '0;
        exp_state = ST_IDLE;
        exp_delay = '0;
        check("mid_reset_state", 64'(bus.deskewState), 64'(ST_IDLE));
        check("mid_reset_delay", 64'(bus.laneDelay),   64'd0);

        // x16, all lanes in one cycle: straight to COMPUTE, zero delays
        start(5'd16, ST_SEARCH);
        search_wait(16);
        clear_sched();
        mk[0] = 16'hFFFF;
        measure(16, 1, dc);
        check("x16_cycle",  64'(dc), 64'd0);
        check("x16_delays", 64'(bus.laneDelay), 64'd0);
        check("x16_locked", 64'(bus.deskewLocked), 64'd1);

        // x8, lane 7 never marks
        do_reset();
        start(5'd8, ST_SEARCH);
        search_wait(8);
        clear_sched();
        mk[0] = 16'h0001; mk[1] = 16'h0006; mk[5] = 16'h0078;
        measure(8, 6, dc);
        check("x8_error",  64'(bus.deskewError),  64'd1);
        check("x8_locked", 64'(bus.deskewLocked), 64'd0);

        // x2 lock, then LANESNUMBER 2 -> 1 drops back to IDLE
        do_reset();
        start(5'd2, ST_SEARCH);
        search_wait(2);
        clear_sched();
        mk[0] = 16'h0002; mk[1] = 16'h0001;
        measure(2, 2, dc);
        check("x2_delays", 64'(bus.laneDelay), 64'h0010);
        bus.LANESNUMBER = 5'd1;
        tick();
        exp_state = ST_IDLE;
        exp_delay = '0;
        check("x2_drop_locked", 64'(bus.deskewLocked), 64'd0);
        check("x2_drop_delay",  64'(bus.laneDelay),    64'd0);

        // LANESNUMBER 0 is rejected; then x4 with lane 5 markers ignored
        start(5'd0, ST_ERROR);
        check("ln0_error", 64'(bus.deskewError), 64'd1);
        start(5'd4, ST_SEARCH);
        search_wait(4);
        clear_sched();
        mk[0] = 16'h0001; mk[1] = 16'h0020; mk[2] = 16'h000E;
        measure(4, 3, dc);
        check("inactive_delays", 64'(bus.laneDelay), 64'h0002);

        // GEN change while searching aborts to IDLE
        start(5'd4, ST_SEARCH);
        bus.GEN = 3'd3;
        tick();
        exp_state = ST_IDLE;
        check("gen_abort", 64'(bus.deskewState), 64'(ST_IDLE));
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
